execute_stage_md: RTL and testbench
===================================

Name: execute_stage_md

Overview:
Parametrised successor of the single-cycle execute stage, generalised in XLEN. It keeps the same operand forwarding muxes and the single-cycle ALU path. It adds an iterative RV32M multiply/divide engine with a stall handshake to the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
XLEN, 32, datapath width (multiple of 8).
BITS_PER_CYCLE, 1, multiply/divide bits retired per iteration. Legal values are 1, 2 and 4, and the value must divide XLEN.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  ID/EX holds a valid instruction
flush  in  1  kill the instruction in EX, including any in-flight mul/div
imm  in  XLEN  immediate
rs1_data  in  XLEN  register file rs1
rs2_data  in  XLEN  register file rs2
sel_op1  in  2  op1 forward select: 00 rs1, 01 wb_result, 10 alu_result_mem, 11 zero
sel_op2  in  2  op2 forward select: 00 imm-or-rs2, 01 wb_result, 10 alu_result_mem, 11 zero
alu_result_mem  in  XLEN  forward from EX/MEM
wb_result  in  XLEN  forward from MEM/WB
alu_src  in  1  1 = imm replaces rs2 before the op2 forward mux
alu_op  in  4  ALU operation (existing encoding)
md_en  in  1  instruction is mul/div
md_op  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 order)
result  out  XLEN  ALU result, or mul/div result in DONE
operand2  out  XLEN  forwarded op2, used as store data
out_valid  out  1  result valid this cycle
stall  out  1  freeze PC, IF/ID and ID/EX, and insert a bubble into EX/MEM
busy  out  1  mul/div engine not IDLE

Behaviour:
- Reset values: FSM in IDLE; counter 0; internal registers 0. Outputs out_valid=0, stall=0, busy=0, result=0.
- Forward muxes and the ALU are combinational, with the same semantics as the current stage.
- ALU path: when in_valid & !md_en & FSM in IDLE:
  - out_valid=1 in the same cycle.
  - result=ALU output.
  - Zero latency, no stall.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE -> BUSY on in_valid & md_en & !flush. On this issue cycle:
  - Latch forwarded op1/op2 and md_op, because forwarding sources change while stalled.
  - Assert stall combinationally in the issue cycle.
  - Load counter = XLEN/BITS_PER_CYCLE.
  - Signed ops: operands are converted to magnitude plus a sign flag. Final sign is applied in the last iteration.
- Special cases are detected at issue and skip BUSY, going IDLE -> DONE directly:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (most-negative / -1): DIV gives the dividend; REM gives 0.
- BUSY:
  - Each cycle retires BITS_PER_CYCLE bits of shift-add multiply or restoring division, and decrements the counter.
  - stall=1 and busy=1.
  - When counter reaches 0, go to DONE.
- Multiply keeps a 2*XLEN product. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- DONE lasts exactly one cycle:
  - stall=0, out_valid=1, result=registered mul/div result.
  - Inputs are ignored; the held instruction is the one just completed and must not re-issue.
  - Then go to IDLE.
- Latency from issue cycle to the DONE cycle:
  - Normal: XLEN/BITS_PER_CYCLE + 1 cycles (33 for the defaults).
  - Special cases: 1 cycle.
- flush in any state: go to IDLE next cycle. out_valid=0 and stall=0 in the flush cycle. Flush has priority over issue and over DONE.
- reset mid-operation: same as flush, and clears all registers.
- in_valid=0 in IDLE: out_valid=0, result undefined but stable.
- operand2 always shows the live forwarded op2, not the latched value.

Decomposition:
- Package ex_pkg holds:
  - alu_op codes;
  - md_op enum;
  - fwd_sel enum {FWD_REG, FWD_WB, FWD_MEM, FWD_ZERO};
  - md_state enum.
- Sub-module muldiv_iter (XLEN, BITS_PER_CYCLE) contains the FSM, counter, and mul/div datapath.
- The top level contains the forward muxes, the ALU instance, and the result/valid/stall muxing.

Test Plan:
- ADD with sel_op1=10 (alu_result_mem=5) and rs2=3 -> result=8, out_valid in the same cycle, stall=0.
- MUL with op1=7, op2=0xFFFFFFFD -> stall high for 33 cycles from issue, then a 1-cycle DONE with result=0xFFFFFFEB. Forward sources are changed every BUSY cycle and must have no effect.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU of the same operands -> 0x40000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 7, both in DONE one cycle after issue. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. DIVU 100/7 -> 14, REMU -> 2.
- Flush at BUSY cycle 10 -> IDLE next cycle, no out_valid, stall=0. An immediately following ADD completes normally.
- reset at BUSY cycle 5 -> all outputs 0 the next cycle. BITS_PER_CYCLE=4 rerun of the MUL case -> DONE after 9 cycles.

Source files
------------

// File: rtl/execute_stage_md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared encodings for the execute stage with mul/div:
//                ALU operation codes, RV32M md_op (funct3 order), forward
//                mux selects and mul/div engine state encoding.
//  Revision    : 1.0 - initial XLEN-parametrised release
// ============================================================================
package ex_pkg;

    // ALU operation codes (existing single-cycle stage encoding)
    localparam logic [3:0] c_ALU_ADD   = 4'd0;
    localparam logic [3:0] c_ALU_SUB   = 4'd1;
    localparam logic [3:0] c_ALU_SLL   = 4'd2;
    localparam logic [3:0] c_ALU_SLT   = 4'd3;
    localparam logic [3:0] c_ALU_SLTU  = 4'd4;
    localparam logic [3:0] c_ALU_XOR   = 4'd5;
    localparam logic [3:0] c_ALU_SRL   = 4'd6;
    localparam logic [3:0] c_ALU_SRA   = 4'd7;
    localparam logic [3:0] c_ALU_OR    = 4'd8;
    localparam logic [3:0] c_ALU_AND   = 4'd9;
    localparam logic [3:0] c_ALU_PASSB = 4'd10;

    // RV32M operations, funct3 order
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    // Operand forward selects
    typedef enum logic [1:0] {
        FWD_REG  = 2'd0,
        FWD_WB   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_e;

    // Mul/div engine states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/execute_stage_md_alu.sv
`default_nettype none
// ============================================================================
//  Module      : ex_alu
//  Description : Single-cycle combinational ALU of the execute stage.
//  Ports       : i_op  - ALU operation code (ex_pkg c_ALU_*)
//                i_a   - operand 1
//                i_b   - operand 2 (shift amount in the low log2(XLEN) bits)
//                o_y   - result
//  Revision    : 1.0 - initial XLEN-parametrised release
// ============================================================================
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);

    localparam int c_SW = $clog2(XLEN);

    logic [c_SW-1:0] w_sh;
    assign w_sh = i_b[c_SW-1:0];

    always_comb begin
        o_y = '0;
        case (i_op)
            c_ALU_ADD:   o_y = i_a + i_b;
            c_ALU_SUB:   o_y = i_a - i_b;
            c_ALU_SLL:   o_y = i_a << w_sh;
            c_ALU_SLT:   o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            c_ALU_SLTU:  o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
            c_ALU_XOR:   o_y = i_a ^ i_b;
            c_ALU_SRL:   o_y = i_a >> w_sh;
            c_ALU_SRA:   o_y = $signed(i_a) >>> w_sh;
            c_ALU_OR:    o_y = i_a | i_b;
            c_ALU_AND:   o_y = i_a & i_b;
            c_ALU_PASSB: o_y = i_b;
            default:     o_y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage_md_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Iterative RV32M multiply/divide engine. Shift-add multiply
//                and restoring division on operand magnitudes, retiring
//                BITS_PER_CYCLE bits per cycle; the sign is applied when the
//                last iteration writes the result register. Divide-by-zero
//                and signed overflow skip the iterations entirely.
//                BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN.
//  Ports       : clk, rst    - clock, synchronous active-high reset
//                i_flush     - abort any operation, return to idle
//                i_start     - valid mul/div instruction presented
//                i_md_op     - operation (funct3 order)
//                i_op_a/b    - forwarded operands (sampled at issue)
//                o_idle/o_iter/o_done - state decodes
//                o_issue     - operation accepted this cycle
//                o_result    - registered result, meaningful in DONE
//  Revision    : 1.0 - initial XLEN-parametrised release
// ============================================================================
module muldiv_iter
    import ex_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_start,
    input  logic [2:0]      i_md_op,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_idle,
    output logic            o_iter,
    output logic            o_done,
    output logic            o_issue,
    output logic [XLEN-1:0] o_result
);

    localparam int c_ITER = XLEN / BITS_PER_CYCLE;
    localparam int c_CW   = $clog2(c_ITER + 1);

    localparam logic [c_CW-1:0] c_ITER_LD = c_CW'(c_ITER);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);
    localparam logic [XLEN-1:0] c_MIN     = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_ST_IDLE = MD_IDLE;
    localparam logic [1:0] c_ST_BUSY = MD_BUSY;
    localparam logic [1:0] c_ST_DONE = MD_DONE;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [XLEN-1:0] r_hi;      // product high half / partial remainder
    logic [XLEN-1:0] r_lo;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0] r_b;       // multiplicand / divisor magnitude
    logic [XLEN-1:0] r_result;

    // ------------------------------------------------------------------
    // Issue-time decode: signedness, magnitudes, special cases
    // ------------------------------------------------------------------
    logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_neg;
    logic            w_div0, w_ovf;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special;

    always_comb begin
        w_is_div   = i_md_op[2];
        w_a_signed = (i_md_op == MD_MULH) || (i_md_op == MD_MULHSU) ||
                     (i_md_op == MD_DIV)  || (i_md_op == MD_REM);
        w_b_signed = (i_md_op == MD_MULH) || (i_md_op == MD_DIV) ||
                     (i_md_op == MD_REM);
        w_sa       = w_a_signed & i_op_a[XLEN-1];
        w_sb       = w_b_signed & i_op_b[XLEN-1];
        w_mag_a    = w_sa ? -i_op_a : i_op_a;
        w_mag_b    = w_sb ? -i_op_b : i_op_b;
        // remainder takes the dividend's sign, everything else the xor
        w_neg      = (w_is_div & i_md_op[1]) ? w_sa : (w_sa ^ w_sb);
        w_div0     = w_is_div & (i_op_b == '0);
        // only DIV/REM (bit0 clear) can overflow
        w_ovf      = w_is_div & ~i_md_op[0] & (i_op_a == c_MIN) & (i_op_b == '1);
        if (w_div0)
            w_special = i_md_op[1] ? i_op_a : '1;
        else
            w_special = i_md_op[1] ? '0 : i_op_a;
    end

    // ------------------------------------------------------------------
    // One cycle of iterations, unrolled BITS_PER_CYCLE times
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_hi, w_lo;
    logic [XLEN:0]   w_t;

    always_comb begin
        w_hi = r_hi;
        w_lo = r_lo;
        w_t  = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (r_op[2]) begin
                w_t  = {w_hi, w_lo[XLEN-1]};
                w_lo = {w_lo[XLEN-2:0], 1'b0};
                if (w_t >= {1'b0, r_b}) begin
                    w_t     = w_t - {1'b0, r_b};
                    w_lo[0] = 1'b1;
                end
                w_hi = w_t[XLEN-1:0];
            end else begin
                w_t  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : '0);
                w_lo = {w_t[0], w_lo[XLEN-1:1]};
                w_hi = w_t[XLEN:1];
            end
        end
    end

    // Signed result from the values the final iteration produces
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0]   w_q, w_r, w_final;

    always_comb begin
        w_prod   = {w_hi, w_lo};
        w_prod_s = r_neg ? -w_prod : w_prod;
        w_q      = r_neg ? -w_lo : w_lo;
        w_r      = r_neg ? -w_hi : w_hi;
        if (r_op[2])
            w_final = r_op[1] ? w_r : w_q;
        else
            w_final = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    end

    assign o_issue = (r_state == c_ST_IDLE) & i_start & ~i_flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else if (i_flush) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_start) begin
                        r_op  <= i_md_op;
                        r_neg <= w_neg;
                        r_hi  <= '0;
                        r_lo  <= w_mag_a;
                        r_b   <= w_mag_b;
                        if (w_div0 | w_ovf) begin
                            r_result <= w_special;
                            r_state  <= c_ST_DONE;
                        end else begin
                            r_cnt   <= c_ITER_LD;
                            r_state <= c_ST_BUSY;
                        end
                    end
                end
                c_ST_BUSY: begin
                    r_hi  <= w_hi;
                    r_lo  <= w_lo;
                    r_cnt <= r_cnt - c_ONE;
                    if (r_cnt == c_ONE) begin
                        r_result <= w_final;
                        r_state  <= c_ST_DONE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_idle   = (r_state == c_ST_IDLE);
    assign o_iter   = (r_state == c_ST_BUSY);
    assign o_done   = (r_state == c_ST_DONE);
    assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/execute_stage_md.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_md
//  Description : Execute stage between ID/EX and EX/MEM. Operand forward
//                muxes, single-cycle ALU and an iterative RV32M engine that
//                stalls the front of the pipeline while it runs.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                in_valid, flush      - ID/EX valid, kill instruction in EX
//                imm, rs1/rs2_data    - immediate and register operands
//                sel_op1/2            - forward selects (reg/wb/mem/zero)
//                alu_result_mem, wb_result - forwarded values
//                alu_src, alu_op      - op2 immediate select, ALU operation
//                md_en, md_op         - mul/div instruction and operation
//                result, operand2     - result, live forwarded op2 (store data)
//                out_valid, stall, busy - handshake to EX/MEM and hazard unit
//  Revision    : 1.0 - initial XLEN-parametrised release
// ============================================================================
module execute_stage_md
    import ex_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [1:0]      sel_op1,
    input  logic [1:0]      sel_op2,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] wb_result,
    input  logic            alu_src,
    input  logic [3:0]      alu_op,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] operand2,
    output logic            out_valid,
    output logic            stall,
    output logic            busy
);

    logic [XLEN-1:0] w_op1, w_op2_base, w_op2, w_alu_y, w_md_result;
    logic            w_md_idle, w_md_iter, w_md_done, w_md_issue;
    logic            w_kill, w_alu_fire, w_done_fire;

    // Forward muxes
    assign w_op2_base = alu_src ? imm : rs2_data;

    always_comb begin
        case (fwd_sel_e'(sel_op1))
            FWD_REG: w_op1 = rs1_data;
            FWD_WB:  w_op1 = wb_result;
            FWD_MEM: w_op1 = alu_result_mem;
            default: w_op1 = '0;
        endcase
    end

    always_comb begin
        case (fwd_sel_e'(sel_op2))
            FWD_REG: w_op2 = w_op2_base;
            FWD_WB:  w_op2 = wb_result;
            FWD_MEM: w_op2 = alu_result_mem;
            default: w_op2 = '0;
        endcase
    end

    assign operand2 = w_op2;

    ex_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_op (alu_op),
        .i_a  (w_op1),
        .i_b  (w_op2),
        .o_y  (w_alu_y)
    );

    muldiv_iter #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_md (
        .clk      (clk),
        .rst      (reset),
        .i_flush  (flush),
        .i_start  (in_valid & md_en),
        .i_md_op  (md_op),
        .i_op_a   (w_op1),
        .i_op_b   (w_op2),
        .o_idle   (w_md_idle),
        .o_iter   (w_md_iter),
        .o_done   (w_md_done),
        .o_issue  (w_md_issue),
        .o_result (w_md_result)
    );

    // Reset behaves like a flush for the combinational outputs.
    // In DONE the ID/EX inputs still show the finished instruction, so the
    // ALU path is only open while the engine is idle.
    assign w_kill      = flush | reset;
    assign w_alu_fire  = in_valid & ~md_en & w_md_idle & ~w_kill;
    assign w_done_fire = w_md_done & ~w_kill;

    assign out_valid = w_alu_fire | w_done_fire;
    assign stall     = ~w_kill & (w_md_issue | w_md_iter);
    assign busy      = ~w_md_idle;
    assign result    = w_done_fire ? w_md_result : (w_alu_fire ? w_alu_y : '0);

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_md.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage_md
//  Description : Self-checking bench for execute_stage_md. Two instances:
//                BITS_PER_CYCLE=1 and BITS_PER_CYCLE=4, sharing all inputs
//                except in_valid. Expected values come from a plain
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage_md;
    import ex_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, in_valid, in_valid4, flush, alu_src, md_en;
    logic [XLEN-1:0] imm, rs1_data, rs2_data, alu_result_mem, wb_result;
    logic [1:0]      sel_op1, sel_op2;
    logic [3:0]      alu_op;
    logic [2:0]      md_op;
    logic [XLEN-1:0] result, operand2, result4, operand2_4;
    logic            out_valid, stall, busy, out_valid4, stall4, busy4;

    int n_tests = 0;
    int n_fail  = 0;

    execute_stage_md #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .sel_op1(sel_op1), .sel_op2(sel_op2),
        .alu_result_mem(alu_result_mem), .wb_result(wb_result),
        .alu_src(alu_src), .alu_op(alu_op), .md_en(md_en), .md_op(md_op),
        .result(result), .operand2(operand2), .out_valid(out_valid),
        .stall(stall), .busy(busy)
    );

    execute_stage_md #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .flush(flush),
        .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .sel_op1(sel_op1), .sel_op2(sel_op2),
        .alu_result_mem(alu_result_mem), .wb_result(wb_result),
        .alu_src(alu_src), .alu_op(alu_op), .md_en(md_en), .md_op(md_op),
        .result(result4), .operand2(operand2_4), .out_valid(out_valid4),
        .stall(stall4), .busy(busy4)
    );

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] regv);
        case (sel)
            2'd0:    return regv;
            2'd1:    return wb_result;
            2'd2:    return alu_result_mem;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return 32'(int'(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (op < 3'd4) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (is_special(op, a, b)) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (is_special(op, a, b)) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic run_alu(input string tag, input logic [3:0] op, input logic [1:0] s1,
                           input logic [1:0] s2, input logic src);
        logic [31:0] a, b;
        @(posedge clk); #1;
        in_valid = 1'b1; md_en = 1'b0; alu_op = op;
        sel_op1 = s1; sel_op2 = s2; alu_src = src;
        a = ref_fwd(s1, rs1_data);
        b = ref_fwd(s2, src ? imm : rs2_data);
        @(negedge clk);
        check_eq({tag, " valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, " stall"}, 32'(stall), 32'd0);
        check_eq({tag, " result"}, result, ref_alu(op, a, b));
        check_eq({tag, " operand2"}, operand2, b);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit use4, input bit scramble);
        int lat_exp, stall_cnt, cyc;
        bit got;
        logic ov, st, bz;
        logic [31:0] res;
        lat_exp   = is_special(op, a, b) ? 1 : (XLEN / (use4 ? 4 : 1)) + 1;
        stall_cnt = 0;
        cyc       = 0;
        got       = 1'b0;
        @(posedge clk); #1;
        rs1_data = a; rs2_data = b; sel_op1 = 2'd0; sel_op2 = 2'd0; alu_src = 1'b0;
        md_en = 1'b1; md_op = op;
        if (use4) in_valid4 = 1'b1; else in_valid = 1'b1;
        @(negedge clk);
        ov = use4 ? out_valid4 : out_valid;
        st = use4 ? stall4 : stall;
        check_eq({tag, " issue valid"}, 32'(ov), 32'd0);
        if (st) stall_cnt++;
        for (int i = 1; i <= lat_exp + 4 && !got; i++) begin
            @(posedge clk); #1;
            if (scramble) begin
                rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
                wb_result = $urandom; alu_result_mem = $urandom;
                sel_op1 = 2'($urandom_range(0, 3)); sel_op2 = 2'($urandom_range(0, 3));
                alu_src = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            ov  = use4 ? out_valid4 : out_valid;
            st  = use4 ? stall4 : stall;
            res = use4 ? result4 : result;
            if (ov) begin
                got = 1'b1;
                cyc = i;
                check_eq({tag, " result"}, res, ref_md(op, a, b));
                check_eq({tag, " done stall"}, 32'(st), 32'd0);
            end else if (st) begin
                stall_cnt++;
            end
        end
        if (!got) check_eq({tag, " timeout"}, 32'd0, 32'd1);
        check_eq({tag, " latency"}, 32'(cyc), 32'(lat_exp));
        check_eq({tag, " stall cycles"}, 32'(stall_cnt), 32'(lat_exp));
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid4 = 1'b0; md_en = 1'b0;
        @(negedge clk);
        bz = use4 ? busy4 : busy;
        check_eq({tag, " idle after"}, 32'(bz), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; flush = 1'b0; alu_src = 1'b0;
        md_en = 1'b0; imm = '0; rs1_data = '0; rs2_data = '0; alu_result_mem = '0;
        wb_result = '0; sel_op1 = '0; sel_op2 = '0; alu_op = '0; md_op = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("reset valid", 32'(out_valid), 32'd0);
        check_eq("reset stall", 32'(stall), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset result", result, 32'd0);
        check_eq("reset busy4", 32'(busy4), 32'd0);

        // ADD with op1 forwarded from EX/MEM
        alu_result_mem = 32'd5; rs2_data = 32'd3;
        run_alu("add fwd", c_ALU_ADD, 2'd2, 2'd0, 1'b0);

        // Random ALU operations with random forwarding
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
            wb_result = $urandom; alu_result_mem = $urandom;
            run_alu("alu rnd", 4'($urandom_range(0, 10)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1 in_valid = 1'b0;

        // Directed mul/div
        run_md("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 1'b0, 1'b1);
        run_md("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_md("mulhu",  3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, 1'b0);
        run_md("div0",   3'd4, 32'd7,         32'd0,         1'b0, 1'b0);
        run_md("rem0",   3'd6, 32'd7,         32'd0,         1'b0, 1'b0);
        run_md("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_md("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_md("divu",   3'd5, 32'd100,       32'd7,         1'b0, 1'b0);
        run_md("remu",   3'd7, 32'd100,       32'd7,         1'b0, 1'b0);
        run_md("mul x4", 3'd0, 32'd7,         32'hFFFF_FFFD, 1'b1, 1'b1);

        // Random mul/div with biased special cases, on both instances
        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_md("md rnd", rop, ra, rb, (i % 3) == 0, 1'b1);
        end

        // Flush at BUSY cycle 10, then an ADD right behind it
        @(posedge clk); #1;
        rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; sel_op1 = 2'd0; sel_op2 = 2'd0;
        alu_src = 1'b0; md_en = 1'b1; md_op = 3'd0; in_valid = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush valid", 32'(out_valid), 32'd0);
        check_eq("flush stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; md_en = 1'b0; alu_op = c_ALU_ADD; rs1_data = 32'd20; rs2_data = 32'd22;
        @(negedge clk);
        check_eq("post-flush busy", 32'(busy), 32'd0);
        check_eq("post-flush valid", 32'(out_valid), 32'd1);
        check_eq("post-flush stall", 32'(stall), 32'd0);
        check_eq("post-flush add", result, 32'd42);
        @(posedge clk); #1 in_valid = 1'b0;

        // Reset at BUSY cycle 5
        @(posedge clk); #1;
        rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; md_en = 1'b1; md_op = 3'd0; in_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        check_eq("pre-reset busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("reset-cycle stall", 32'(stall), 32'd0);
        check_eq("reset-cycle valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; md_en = 1'b0;
        @(negedge clk);
        check_eq("post-reset valid", 32'(out_valid), 32'd0);
        check_eq("post-reset stall", 32'(stall), 32'd0);
        check_eq("post-reset busy", 32'(busy), 32'd0);
        check_eq("post-reset result", result, 32'd0);

        // Engine usable again after reset
        run_md("mul after reset", 3'd0, 32'd12, 32'd11, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
